alu_issue_ctrl: RTL and testbench

//  Execute-stage sequencer that drives the MAK-8 combinational ALU. Accepts one decoded ALU

---
 rtl/alu_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage sequencer for the MAK-8 ALU, owning the register file and flags.
// Define ALU_ISSUE_FAST_EN to drop the WB state and write back straight from the ALU in EXEC.
module alu_issue_ctrl #(
   parameter  int NREGS  = 4,
   localparam int REG_AW = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [REG_AW-1:0] in_rs,
   input  logic              in_imm_sel,
   input  logic [7:0]        in_imm,
   input  logic              in_no_wb,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [2:0]        alu_op,
   input  logic [7:0]        alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_negative,
   output logic              done,
   output logic [2:0]        flags,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [7:0]        dbg_data
);
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d, done_q, done_d;
   logic              imm_sel_q, imm_sel_d, no_wb_q, no_wb_d;
   logic [2:0]        op_q, op_d, flags_q, flags_d;
   logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d;
   logic [7:0]        imm_q, imm_d, a_q, a_d, b_q, b_d;
   logic [7:0]        regs_q [NREGS];
   logic [7:0]        regs_d [NREGS];
`ifndef ALU_ISSUE_FAST_EN
   logic [7:0]        res_q, res_d;
   logic [2:0]        flg_q, flg_d;
`endif
   always_comb begin
      state_d    = state_q;
      in_ready_d = in_ready_q;
      done_d     = 1'b0;
      op_d       = op_q;
      rd_d       = rd_q;
      rs_d       = rs_q;
      imm_sel_d  = imm_sel_q;
      imm_d      = imm_q;
      no_wb_d    = no_wb_q;
      a_d        = a_q;
      b_d        = b_q;
      flags_d    = flags_q;
      regs_d     = regs_q;
`ifndef ALU_ISSUE_FAST_EN
      res_d      = res_q;
      flg_d      = flg_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            op_d       = in_op;
            rd_d       = in_rd;
            rs_d       = in_rs;
            imm_sel_d  = in_imm_sel;
            imm_d      = in_imm;
            no_wb_d    = in_no_wb;
            state_d    = READ;
            in_ready_d = 1'b0;
         end
         READ: begin
            a_d     = regs_q[rd_q];
            b_d     = imm_sel_q ? imm_q : regs_q[rs_q];
            state_d = EXEC;
`ifdef ALU_ISSUE_FAST_EN
            done_d  = 1'b1;
`endif
         end
         EXEC: begin
`ifdef ALU_ISSUE_FAST_EN
            if (!no_wb_q) regs_d[rd_q] = alu_result;
            flags_d    = {alu_negative, alu_carry, alu_zero};
            state_d    = IDLE;
            in_ready_d = 1'b1;
`else
            res_d   = alu_result;
            flg_d   = {alu_negative, alu_carry, alu_zero};
            state_d = WB;
            done_d  = 1'b1;
`endif
         end
`ifndef ALU_ISSUE_FAST_EN
         WB: begin
            if (!no_wb_q) regs_d[rd_q] = res_q;
            flags_d    = flg_q;
            state_d    = IDLE;
            in_ready_d = 1'b1;
         end
`endif
         default: begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b1;
         done_q     <= 1'b0;
         op_q       <= '0;
         rd_q       <= '0;
         rs_q       <= '0;
         imm_sel_q  <= 1'b0;
         imm_q      <= '0;
         no_wb_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         flags_q    <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifndef ALU_ISSUE_FAST_EN
         res_q      <= '0;
         flg_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         done_q     <= done_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         rs_q       <= rs_d;
         imm_sel_q  <= imm_sel_d;
         imm_q      <= imm_d;
         no_wb_q    <= no_wb_d;
         a_q        <= a_d;
         b_q        <= b_d;
         flags_q    <= flags_d;
         regs_q     <= regs_d;
`ifndef ALU_ISSUE_FAST_EN
         res_q      <= res_d;
         flg_q      <= flg_d;
`endif
      end
   end
   assign in_ready = in_ready_q;
   assign done     = done_q;
   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = op_q;
   assign flags    = flags_q;
   assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a reference ALU and a scoreboard of expected write-backs.
module tb_alu_issue_ctrl;
   localparam int NREGS = 4;
`ifdef ALU_ISSUE_FAST_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif
   localparam logic [2:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, NOT_ = 5, SHL = 6, SHR = 7;
   logic       clk = 1'b0, rst, in_valid, in_ready, in_imm_sel, in_no_wb, done;
   logic [2:0] in_op, alu_op, flags;
   logic [1:0] in_rd, in_rs, dbg_addr;
   logic [7:0] in_imm, alu_a, alu_b, alu_result, dbg_data;
   logic       alu_zero, alu_carry, alu_negative;
   int         pass_n = 0, total_n = 0, cyc = 0, acc_cyc = 0;
   logic [7:0] mreg [NREGS];
   typedef struct {logic [1:0] rd; logic [7:0] val; logic [2:0] flg;} exp_t;
   exp_t       sbq [$];

   alu_issue_ctrl #(.NREGS(NREGS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs(in_rs), .in_imm_sel(in_imm_sel), .in_imm(in_imm),
      .in_no_wb(in_no_wb), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_negative(alu_negative), .done(done), .flags(flags), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Returns {N,C,Z,result}; serves as both the ALU stand-in and the expectation source.
   function automatic logic [10:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] t;
      logic [7:0] r;
      logic       c;
      int         s;
      s = int'(b[2:0]);
      c = 1'b0;
      t = '0;
      case (op)
         ADD:     begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
         SUB:     begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; end
         AND_:    r = a & b;
         OR_:     r = a | b;
         XOR_:    r = a ^ b;
         NOT_:    r = ~a;
         SHL:     begin t = {1'b0, a} << s; r = t[7:0]; c = t[8]; end
         default: begin t = {a, 1'b0} >> s; r = t[8:1]; c = t[0]; end
      endcase
      return {r[7], c, r == 8'h00, r};
   endfunction

   always_comb {alu_negative, alu_carry, alu_zero, alu_result} = alu_ref(alu_op, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_n++;
      assert (obs === exp) pass_n++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic isel, input logic [7:0] imm, input logic nowb);
      logic [10:0] r;
      exp_t e;
      in_op = op; in_rd = rd; in_rs = rs; in_imm_sel = isel; in_imm = imm; in_no_wb = nowb;
      in_valid = 1'b1;
      r = alu_ref(op, mreg[rd], isel ? imm : mreg[rs]);
      if (!nowb) mreg[rd] = r[7:0];
      e.rd = rd; e.val = mreg[rd]; e.flg = r[10:8];
      sbq.push_back(e);
   endtask

   task automatic accept();
      int w = 0;
      while (!in_ready && w < 10) begin @(negedge clk); w++; end
      check("in_ready_at_accept", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1 acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic complete();
      int   k;
      logic rdy_seen = 1'b0;
      exp_t e;
      for (k = 1; k <= 8; k++) begin
         @(negedge clk);
         rdy_seen |= in_ready;
         if (done) break;
      end
      check("done_latency", k, LAT);
      check("ready_low_while_busy", {31'b0, rdy_seen}, 0);
      check("done_cycle_vs_accept", cyc - acc_cyc + 1, LAT);
      @(negedge clk);
      e = sbq.pop_front();
      dbg_addr = e.rd;
      #1;
      check("wb_reg", dbg_data, e.val);
      check("wb_flags", flags, e.flg);
      check("done_one_cycle", {31'b0, done}, 0);
      check("ready_after_wb", {31'b0, in_ready}, 1);
   endtask

   task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic isel, input logic [7:0] imm, input logic nowb);
      @(negedge clk);
      send(op, rd, rs, isel, imm, nowb);
      accept();
      complete();
   endtask

   task automatic expect_reg(input string tag, input logic [1:0] rd, input logic [7:0] val);
      dbg_addr = rd;
      #1 check(tag, dbg_data, val);
   endtask

   initial begin
      int   a1;
      logic done_seen;
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0;
      in_imm_sel = 1'b0; in_imm = '0; in_no_wb = 1'b0; dbg_addr = '0;
      for (int i = 0; i < NREGS; i++) mreg[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 1);
      check("rst_done", {31'b0, done}, 0);
      check("rst_flags", flags, 0);
      check("rst_alu_a", alu_a, 0);
      for (int i = 0; i < NREGS; i++) expect_reg("rst_reg", 2'(i), 8'h00);
      run(ADD, 1, 0, 1, 8'h7F, 0);
      run(ADD, 1, 0, 1, 8'h01, 0);
      expect_reg("add_overflow_r1", 1, 8'h80);
      check("add_overflow_flags", flags, 3'b100);
      run(ADD, 2, 0, 1, 8'hFF, 0);
      run(ADD, 2, 0, 1, 8'h01, 0);
      expect_reg("add_wrap_r2", 2, 8'h00);
      check("add_wrap_flags", flags, 3'b011);
      run(AND_, 1, 0, 1, 8'h00, 0);
      run(ADD, 1, 0, 1, 8'h05, 0);
      run(SUB, 1, 0, 1, 8'h06, 1);
      expect_reg("cmp_r1_kept", 1, 8'h05);
      check("cmp_flags", flags, 3'b110);
      run(OR_, 0, 1, 0, 8'hAA, 0);
      run(ADD, 0, 0, 0, 8'h00, 0);
      expect_reg("rd_eq_rs_r0", 0, 8'h0A);
      run(NOT_, 0, 0, 1, 8'hFF, 0);
      run(SHR, 0, 1, 0, 8'h00, 0);
      run(XOR_, 2, 1, 0, 8'h00, 0);
      run(SHL, 1, 0, 1, 8'h00, 0);
      check("shift0_carry", flags[1], 0);
      @(negedge clk);
      send(ADD, 3, 0, 1, 8'h81, 0);
      accept();
      a1 = acc_cyc;
      send(SHL, 3, 0, 1, 8'h01, 0);
      complete();
      accept();
      check("b2b_spacing", acc_cyc - a1, LAT + 1);
      complete();
      expect_reg("shl_r3", 3, 8'h02);
      check("shl_flags", flags, 3'b010);
      @(negedge clk);
      in_op = ADD; in_rd = 0; in_imm_sel = 1'b1; in_imm = 8'h10; in_no_wb = 1'b0; in_valid = 1'b1;
      accept();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_done", {31'b0, done}, 0);
      check("abort_ready", {31'b0, in_ready}, 1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREGS; i++) mreg[i] = '0;
      done_seen = 1'b0;
      repeat (5) begin @(negedge clk); done_seen |= done; end
      check("abort_no_done", {31'b0, done_seen}, 0);
      check("abort_ready_after", {31'b0, in_ready}, 1);
      check("abort_flags", flags, 0);
      for (int i = 0; i < NREGS; i++) expect_reg("abort_reg", 2'(i), mreg[i]);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end
endmodule
